// File: rtl/operand_fetch_pkg.sv
`timescale 1ns/1ps
// operand_fetch_pkg
// Shared widths and the staged-instruction record for the operand fetch stage.
// OF_ADDRESS_WIDTH / OF_DATA_WIDTH are the default register address and data
// widths; staged_instruction_t is the record held in the output register.
package operand_fetch_pkg;

    localparam int OF_ADDRESS_WIDTH = 2;
    localparam int OF_DATA_WIDTH    = 8;

    typedef struct packed {
        logic [OF_DATA_WIDTH-1:0]    operand_1;
        logic [OF_DATA_WIDTH-1:0]    operand_2;
        logic [OF_ADDRESS_WIDTH-1:0] destination;
        logic                        write_back;
    } staged_instruction_t;

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
`timescale 1ns/1ps
// operand_scoreboard
// Per-register busy bits tracking outstanding writes.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   set_valid/set_address       mark a register busy (issued writer)
//   clear_valid/clear_address   writeback retires a register
//   flush_clear_valid/_address  squashed writer releases its register
//   lookup_address_1..3         registers to examine this cycle
//   lookup_busy_1..3            effective busy: busy and not being written back now
module operand_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = OF_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_valid,
    input  logic [ADDRESS_WIDTH-1:0] set_address,
    input  logic                     clear_valid,
    input  logic [ADDRESS_WIDTH-1:0] clear_address,
    input  logic                     flush_clear_valid,
    input  logic [ADDRESS_WIDTH-1:0] flush_clear_address,
    input  logic [ADDRESS_WIDTH-1:0] lookup_address_1,
    input  logic [ADDRESS_WIDTH-1:0] lookup_address_2,
    input  logic [ADDRESS_WIDTH-1:0] lookup_address_3,
    output logic                     lookup_busy_1,
    output logic                     lookup_busy_2,
    output logic                     lookup_busy_3
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    // Set is applied last so a new writer wins over a same-cycle retire.
    always_comb begin
        busy_next = busy;
        if (clear_valid)
            busy_next[clear_address] = 1'b0;
        if (flush_clear_valid)
            busy_next[flush_clear_address] = 1'b0;
        if (set_valid)
            busy_next[set_address] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // A register being written back this cycle is bypassed, so it is not a hazard.
    assign lookup_busy_1 = busy[lookup_address_1] && !(clear_valid && clear_address == lookup_address_1);
    assign lookup_busy_2 = busy[lookup_address_2] && !(clear_valid && clear_address == lookup_address_2);
    assign lookup_busy_3 = busy[lookup_address_3] && !(clear_valid && clear_address == lookup_address_3);

endmodule

// File: rtl/operand_fetch_stage.sv
`timescale 1ns/1ps
// operand_fetch_stage
// Reads register operands, checks RAW/WAW hazards against the busy scoreboard,
// bypasses same-cycle writeback data and holds one issued instruction for execute.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_valid/in_ready + in_*           decoded instruction handshake and fields
//   address_1/2, read_data_1/2         register file read port (combinational)
//   writeback_valid/_address/_data     writeback stage register write
//   flush                              squash the staged instruction
//   out_valid/out_ready + out_*        staged instruction towards execute
module operand_fetch_stage
    import operand_fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = OF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = OF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] in_source_1,
    input  logic [ADDRESS_WIDTH-1:0] in_source_2,
    input  logic                     in_use_immediate,
    input  logic [DATA_WIDTH-1:0]    in_immediate,
    input  logic [ADDRESS_WIDTH-1:0] in_destination,
    input  logic                     in_write_back,
    output logic [ADDRESS_WIDTH-1:0] address_1,
    output logic [ADDRESS_WIDTH-1:0] address_2,
    input  logic [DATA_WIDTH-1:0]    read_data_1,
    input  logic [DATA_WIDTH-1:0]    read_data_2,
    input  logic                     writeback_valid,
    input  logic [ADDRESS_WIDTH-1:0] writeback_address,
    input  logic [DATA_WIDTH-1:0]    writeback_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_operand_1,
    output logic [DATA_WIDTH-1:0]    out_operand_2,
    output logic [ADDRESS_WIDTH-1:0] out_destination,
    output logic                     out_write_back
);

    logic busy_source_1;
    logic busy_source_2;
    logic busy_destination;
    logic hazard;
    logic accept;
    logic hit_1;
    logic hit_2;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;

    assign address_1 = in_source_1;
    assign address_2 = in_source_2;

    // Only one outstanding writer per register, so a busy destination stalls (WAW).
    assign hazard = busy_source_1
                 || (!in_use_immediate && busy_source_2)
                 || (in_write_back && busy_destination);

    assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign hit_1 = writeback_valid && (writeback_address == in_source_1);
    assign hit_2 = writeback_valid && (writeback_address == in_source_2);

    assign operand_1 = hit_1 ? writeback_data : read_data_1;
    assign operand_2 = in_use_immediate ? in_immediate
                     : (hit_2 ? writeback_data : read_data_2);

    operand_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk                 (clk),
        .reset               (reset),
        .set_valid           (accept && in_write_back),
        .set_address         (in_destination),
        .clear_valid         (writeback_valid),
        .clear_address       (writeback_address),
        // Only a live staged writer owns its busy bit; a consumed one still awaits writeback.
        .flush_clear_valid   (flush && out_valid && out_write_back),
        .flush_clear_address (out_destination),
        .lookup_address_1    (in_source_1),
        .lookup_address_2    (in_source_2),
        .lookup_address_3    (in_destination),
        .lookup_busy_1       (busy_source_1),
        .lookup_busy_2       (busy_source_2),
        .lookup_busy_3       (busy_destination)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_operand_1   <= '0;
            out_operand_2   <= '0;
            out_destination <= '0;
            out_write_back  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_operand_1   <= operand_1;
            out_operand_2   <= operand_2;
            out_destination <= in_destination;
            out_write_back  <= in_write_back;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
`timescale 1ns/1ps
module tb_operand_fetch_stage;
    import operand_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_source_1, in_source_2, in_destination;
    logic       in_use_immediate, in_write_back;
    logic [7:0] in_immediate;
    logic [1:0] address_1, address_2;
    logic [7:0] read_data_1, read_data_2;
    logic       writeback_valid;
    logic [1:0] writeback_address;
    logic [7:0] writeback_data;
    logic       flush;
    logic       out_valid, out_ready;
    logic [7:0] out_operand_1, out_operand_2;
    logic [1:0] out_destination;
    logic       out_write_back;

    int n_compared = 0;
    int n_mismatched = 0;

    staged_instruction_t exp_q[$];

    operand_fetch_stage #(.ADDRESS_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_source_1(in_source_1), .in_source_2(in_source_2),
        .in_use_immediate(in_use_immediate), .in_immediate(in_immediate),
        .in_destination(in_destination), .in_write_back(in_write_back),
        .address_1(address_1), .address_2(address_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .writeback_valid(writeback_valid), .writeback_address(writeback_address),
        .writeback_data(writeback_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
        .out_destination(out_destination), .out_write_back(out_write_back)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_source_1 = 0; in_source_2 = 0; in_use_immediate = 0;
        in_immediate = 0; in_destination = 0; in_write_back = 0;
        read_data_1 = 0; read_data_2 = 0;
        writeback_valid = 0; writeback_address = 0; writeback_data = 0; flush = 0;
    endtask

    task automatic issue(input logic [1:0] s1, input logic [1:0] s2, input logic imm,
                         input logic [7:0] immv, input logic [7:0] rd1, input logic [7:0] rd2,
                         input logic [1:0] dest, input logic wbf);
        in_valid = 1; in_source_1 = s1; in_source_2 = s2; in_use_immediate = imm;
        in_immediate = immv; read_data_1 = rd1; read_data_2 = rd2;
        in_destination = dest; in_write_back = wbf;
    endtask

    task automatic push(input logic [7:0] o1, input logic [7:0] o2,
                        input logic [1:0] dest, input logic wbf);
        exp_q.push_back('{operand_1: o1, operand_2: o2, destination: dest, write_back: wbf});
    endtask

    // Cycle model of the handshake and busy bits, evaluated mid-cycle while inputs are stable.
    logic [3:0] m_busy;
    logic       m_ov;
    logic       hold_pend;
    logic [7:0] h_op1, h_op2;
    logic [1:0] h_dest;
    logic       h_wb;

    function automatic logic eb(input logic [1:0] r);
        return m_busy[r] && !(writeback_valid && writeback_address == r);
    endfunction

    always @(negedge clk) begin
        staged_instruction_t front;
        logic hz, exp_rdy, acc;
        if (reset) begin
            check("ready_in_reset", in_ready, 0);
            m_busy = '0; m_ov = 0; hold_pend = 0;
            exp_q.delete();
        end else begin
            hz = eb(in_source_1) || (!in_use_immediate && eb(in_source_2))
                 || (in_write_back && eb(in_destination));
            exp_rdy = !flush && !hz && (!m_ov || out_ready);
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, m_ov);
            if (hold_pend && m_ov) begin
                check("hold_op1", out_operand_1, h_op1);
                check("hold_op2", out_operand_2, h_op2);
                check("hold_dest", out_destination, h_dest);
                check("hold_wb", out_write_back, h_wb);
            end
            hold_pend = m_ov && !out_ready && !flush;
            h_op1 = out_operand_1; h_op2 = out_operand_2;
            h_dest = out_destination; h_wb = out_write_back;
            acc = in_valid && exp_rdy;
            if (writeback_valid) m_busy[writeback_address] = 0;
            if (m_ov && (flush || out_ready)) begin
                if (exp_q.size() == 0) begin
                    check("queue_nonempty", 0, 1);
                end else begin
                    front = exp_q.pop_front();
                    if (flush) begin
                        if (front.write_back) m_busy[front.destination] = 0;
                    end else begin
                        check("out_operand_1", out_operand_1, front.operand_1);
                        check("out_operand_2", out_operand_2, front.operand_2);
                        check("out_destination", out_destination, front.destination);
                        check("out_write_back", out_write_back, front.write_back);
                    end
                end
            end
            if (acc && in_write_back) m_busy[in_destination] = 1;
            m_ov = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_ov;
        end
    end

    typedef struct {
        logic [1:0] s1, s2;
        logic       imm;
        logic [7:0] immv, rd1, rd2;
        logic       wbv;
        logic [1:0] wba;
        logic [7:0] wbd;
        logic [1:0] dest;
        logic [7:0] e1, e2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          s1 s2 imm immv   rd1    rd2    wbv wba wbd   dest e1     e2
        vecs[0] = '{0, 1, 0, 8'h00, 8'hA1, 8'hB2, 0, 0, 8'h00, 1, 8'hA1, 8'hB2};
        vecs[1] = '{2, 3, 1, 8'h7C, 8'h13, 8'hFF, 0, 0, 8'h00, 2, 8'h13, 8'h7C};
        vecs[2] = '{3, 1, 0, 8'h00, 8'h44, 8'h55, 1, 3, 8'h99, 3, 8'h99, 8'h55};
        vecs[3] = '{1, 2, 0, 8'h00, 8'h66, 8'h77, 1, 2, 8'hE3, 0, 8'h66, 8'hE3};
        vecs[4] = '{2, 2, 0, 8'h00, 8'h10, 8'h20, 1, 2, 8'hC4, 1, 8'hC4, 8'hC4};
        vecs[5] = '{0, 0, 1, 8'h00, 8'hFE, 8'h01, 1, 0, 8'h3C, 2, 8'h3C, 8'h00};
        vecs[6] = '{1, 3, 0, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h12, 3, 8'h00, 8'hFF};

        reset = 1; out_ready = 1; idle();
        tick(); tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_op1", out_operand_1, 0);
        check("reset_op2", out_operand_2, 0);
        check("reset_dest", out_destination, 0);
        check("reset_wb", out_write_back, 0);
        check("reset_busy", dut.u_scoreboard.busy, 0);
        reset = 0;

        // Basic issue
        issue(1, 2, 0, 8'h00, 8'h11, 8'h22, 0, 0);
        push(8'h11, 8'h22, 0, 0);
        #1 check("addr_1", address_1, 1);
        check("addr_2", address_2, 2);
        tick(); idle();
        check("basic_valid", out_valid, 1);
        check("basic_op1", out_operand_1, 8'h11);
        check("basic_op2", out_operand_2, 8'h22);
        tick();

        // Table vectors, back to back with out_ready high
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].s1, vecs[i].s2, vecs[i].imm, vecs[i].immv,
                  vecs[i].rd1, vecs[i].rd2, vecs[i].dest, 0);
            writeback_valid = vecs[i].wbv; writeback_address = vecs[i].wba;
            writeback_data = vecs[i].wbd;
            push(vecs[i].e1, vecs[i].e2, vecs[i].dest, 0);
            tick();
        end
        idle(); tick();

        // RAW stall released by same-cycle writeback bypass
        issue(0, 0, 0, 8'h00, 8'h01, 8'h02, 3, 1);
        push(8'h01, 8'h02, 3, 1);
        tick();
        issue(3, 0, 0, 8'h00, 8'h00, 8'h22, 0, 0);
        #1 check("raw_stall", in_ready, 0);
        tick();
        writeback_valid = 1; writeback_address = 3; writeback_data = 8'h5A;
        push(8'h5A, 8'h22, 0, 0);
        #1 check("raw_release", in_ready, 1);
        tick(); idle();
        check("raw_bypass_op1", out_operand_1, 8'h5A);
        check("raw_busy3_clear", dut.u_scoreboard.busy[3], 0);
        tick();

        // Backpressure: hold for three cycles, then accept on the releasing edge
        out_ready = 0;
        issue(1, 2, 0, 8'h00, 8'h31, 8'h32, 1, 0);
        push(8'h31, 8'h32, 1, 0);
        tick();
        issue(2, 3, 0, 8'h00, 8'h41, 8'h42, 2, 0);
        for (int k = 0; k < 3; k++) begin
            #1 check("stall_ready", in_ready, 0);
            tick();
            check("stall_op1", out_operand_1, 8'h31);
            check("stall_valid", out_valid, 1);
        end
        out_ready = 1;
        push(8'h41, 8'h42, 2, 0);
        #1 check("release_ready", in_ready, 1);
        tick(); idle();
        check("release_op1", out_operand_1, 8'h41);
        tick();

        // Immediate operand ignores a busy source 2
        issue(0, 0, 0, 8'h00, 8'h05, 8'h06, 2, 1);
        push(8'h05, 8'h06, 2, 1);
        tick();
        issue(0, 2, 1, 8'hF0, 8'h07, 8'h08, 1, 0);
        push(8'h07, 8'hF0, 1, 0);
        #1 check("imm_no_stall", in_ready, 1);
        tick(); idle();
        check("imm_op2", out_operand_2, 8'hF0);
        writeback_valid = 1; writeback_address = 2;
        tick(); idle();

        // Flush of a staged writer releases its register
        out_ready = 0;
        issue(1, 1, 0, 8'h00, 8'h09, 8'h0A, 2, 1);
        push(8'h09, 8'h0A, 2, 1);
        tick(); idle();
        flush = 1; out_ready = 1;
        #1 check("flush_ready", in_ready, 0);
        tick(); idle();
        check("flush_out_valid", out_valid, 0);
        check("flush_busy2", dut.u_scoreboard.busy[2], 0);
        issue(2, 0, 0, 8'h00, 8'h77, 8'h88, 0, 0);
        push(8'h77, 8'h88, 0, 0);
        #1 check("post_flush_ready", in_ready, 1);
        tick(); idle(); tick();

        // Set wins over clear on the same register
        issue(0, 0, 0, 8'h00, 8'h01, 8'h01, 1, 1);
        push(8'h01, 8'h01, 1, 1);
        tick();
        issue(0, 0, 0, 8'h00, 8'h02, 8'h03, 1, 1);
        writeback_valid = 1; writeback_address = 1; writeback_data = 8'hEE;
        push(8'h02, 8'h03, 1, 1);
        #1 check("waw_bypass_ready", in_ready, 1);
        tick(); idle();
        check("set_wins_busy1", dut.u_scoreboard.busy[1], 1);

        // Reset in the middle of a stall
        out_ready = 0;
        issue(1, 0, 0, 8'h00, 8'hAB, 8'hCD, 2, 0);
        #1 check("mid_stall_ready", in_ready, 0);
        tick();
        reset = 1;
        tick();
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_busy", dut.u_scoreboard.busy, 0);
        check("mid_reset_ready", in_ready, 0);
        reset = 0; out_ready = 1;
        push(8'hAB, 8'hCD, 2, 0);
        #1 check("post_reset_ready", in_ready, 1);
        tick(); idle();
        check("post_reset_valid", out_valid, 1);
        check("post_reset_op1", out_operand_1, 8'hAB);
        tick(); tick();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
